// File: rtl/ic_fetch_unit.sv
// rtl/ic_fetch_unit.sv - instruction fetch initiator: PC, single-outstanding fetch, instruction FIFO
// Optional performance counters are enabled with `define IFU_PERF_EN.
module ic_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          DATA_W   = 32,
  parameter logic [25:0] RESET_PC = 26'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [25:0]       fetch_addr,
  output logic              fetch_en,
  input  logic              fetch_valid,
  input  logic [DATA_W-1:0] fetch_data,
  input  logic              redirect_valid,
  input  logic [25:0]       redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [25:0]       inst_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetches,
  output logic [31:0]       perf_wait_cycles,
  output logic [31:0]       perf_drops
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 26 + DATA_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t              state_q, state_d;
  logic [25:0]         pc_q, pc_d;
  logic                fetch_en_q, fetch_en_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [ENT_W-1:0]    mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d, count_after_pop;
  logic                head_valid_q, head_valid_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic [25:0]         head_pc_q, head_pc_d;
  logic                push, pop, discard;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_en_d   = 1'b0;
    push         = 1'b0;
    discard      = 1'b0;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_pc_d    = head_pc_q;

    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
        end else if (count_q < DEPTH_C) begin
          fetch_en_d = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
          if (fetch_valid) begin
            discard = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (fetch_valid) begin
          push    = 1'b1;
          pc_d    = pc_q + 26'd2;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = redirect_addr;
        // The stale response has arrived either way; nothing else is outstanding.
        if (fetch_valid) begin
          discard = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pop             = head_valid_q && inst_ready;
    count_after_pop = count_q - {{AW{1'b0}}, pop};

    if (redirect_valid) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {pc_q, fetch_data};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d      = count_after_pop + {{AW{1'b0}}, push};
      head_valid_d = (count_d != '0);
      // Head register reloads whenever the current head leaves or the FIFO was empty.
      if (pop || !head_valid_q) begin
        if (count_after_pop == '0) begin
          if (push) begin
            head_pc_d   = pc_q;
            head_data_d = fetch_data;
          end
        end else begin
          {head_pc_d, head_data_d} = mem_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_en_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_en_q   <= fetch_en_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_pc_q    <= head_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fetch_addr = pc_q;
  assign fetch_en   = fetch_en_q;
  assign inst_valid = head_valid_q;
  assign inst_data  = head_data_q;
  assign inst_pc    = head_pc_q;

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_wait_q, perf_wait_d;
  logic [31:0] perf_drops_q, perf_drops_d;

  always_comb begin
    perf_fetches_d = perf_fetches_q;
    perf_wait_d    = perf_wait_q;
    perf_drops_d   = perf_drops_q;
    if (fetch_en_d && perf_fetches_q != 32'hFFFF_FFFF) perf_fetches_d = perf_fetches_q + 32'd1;
    if ((state_q == WAIT || state_q == DROP) && perf_wait_q != 32'hFFFF_FFFF)
      perf_wait_d = perf_wait_q + 32'd1;
    if (discard && perf_drops_q != 32'hFFFF_FFFF) perf_drops_d = perf_drops_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetches_q <= '0;
      perf_wait_q    <= '0;
      perf_drops_q   <= '0;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_wait_q    <= perf_wait_d;
      perf_drops_q   <= perf_drops_d;
    end
  end

  assign perf_fetches     = perf_fetches_q;
  assign perf_wait_cycles = perf_wait_q;
  assign perf_drops       = perf_drops_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_ic_fetch_unit.sv
// tb/tb_ic_fetch_unit.sv - directed self-checking bench for ic_fetch_unit
module tb_ic_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] fetch_addr;
  logic        fetch_en;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        redirect_valid;
  logic [25:0] redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [25:0] inst_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetches, perf_wait_cycles, perf_drops;
`endif

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int cnt;

  ic_fetch_unit #(.DEPTH(4), .DATA_W(32), .RESET_PC(26'h0)) dut (
    .clk(clk), .rst(rst),
    .fetch_addr(fetch_addr), .fetch_en(fetch_en),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef IFU_PERF_EN
    , .perf_fetches(perf_fetches), .perf_wait_cycles(perf_wait_cycles), .perf_drops(perf_drops)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic respond(input logic [31:0] d);
    fetch_valid = 1'b1;
    fetch_data  = d;
    tick();
    fetch_valid = 1'b0;
    fetch_data  = '0;
  endtask

  task automatic redirect(input logic [25:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_fetch(input string tag, input logic [25:0] exp_addr);
    int n = 0;
    while (fetch_en !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_en"}, 64'(fetch_en), 64'(1'b1));
    chk({tag, "_addr"}, 64'(fetch_addr), 64'(exp_addr));
  endtask

  task automatic count_fetches(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (fetch_en === 1'b1) c++;
    end
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_data = '0;
    redirect_valid = 1'b0; redirect_addr = '0; inst_ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_fetch_en", 64'(fetch_en), 64'(0));
    chk("rst_fetch_addr", 64'(fetch_addr), 64'(0));
    chk("rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("rst_inst_data", 64'(inst_data), 64'(0));
    chk("rst_inst_pc", 64'(inst_pc), 64'(0));

    // single pulse after reset, none while waiting
    rst = 1'b0;
    tick();
    chk("first_fetch_en", 64'(fetch_en), 64'(1));
    chk("first_fetch_addr", 64'(fetch_addr), 64'(0));
    count_fetches(100, cnt);
    chk("no_second_fetch", 64'(cnt), 64'(0));

    // redirect, drop the stale response, then fetch from the new PC
    redirect(26'h091A2B3);
    chk("redir_addr_shown", 64'(fetch_addr), 64'(26'h091A2B3));
    respond(32'hBAD0BAD0);
    chk("stale_not_pushed", 64'(inst_valid), 64'(0));
    wait_fetch("redir_fetch", 26'h091A2B3);
    for (int i = 0; i < 5; i++) tick();
    respond(32'hDEADBEEF);
    chk("resp_valid", 64'(inst_valid), 64'(1));
    chk("resp_data", 64'(inst_data), 64'(32'hDEADBEEF));
    chk("resp_pc", 64'(inst_pc), 64'(26'h091A2B3));
    wait_fetch("next_fetch", 26'h091A2B5);

    // fill to DEPTH with decode stalled
    for (int k = 1; k <= 3; k++) begin
      tick();
      respond(32'hA000_0000 + 32'(k));
      if (k < 3) wait_fetch("fill_fetch", 26'h091A2B5 + 26'(2 * k));
    end
    count_fetches(20, cnt);
    chk("full_no_fetch", 64'(cnt), 64'(0));
    chk("full_head_pc", 64'(inst_pc), 64'(26'h091A2B3));
    chk("full_head_data", 64'(inst_data), 64'(32'hDEADBEEF));
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("pop_head_pc", 64'(inst_pc), 64'(26'h091A2B5));
    chk("pop_head_data", 64'(inst_data), 64'(32'hA000_0001));
    wait_fetch("pop_fetch", 26'h091A2BB);
    count_fetches(20, cnt);
    chk("pop_one_fetch", 64'(cnt), 64'(0));

    // redirect while waiting: flush, drop the response 3 cycles later
    redirect(26'h0000100);
    chk("flush_valid", 64'(inst_valid), 64'(0));
`ifdef IFU_PERF_EN
    chk("perf_drops_before", 64'(perf_drops), 64'(1));
`endif
    tick(); tick();
    respond(32'h11111111);
    chk("drop_valid", 64'(inst_valid), 64'(0));
`ifdef IFU_PERF_EN
    chk("perf_drops_after", 64'(perf_drops), 64'(2));
`endif
    wait_fetch("drop_fetch", 26'h0000100);
    chk("drop_still_empty", 64'(inst_valid), 64'(0));

    // redirect coinciding with a response while two entries are held
    respond(32'h0000_00C1);
    wait_fetch("two_a", 26'h0000102);
    respond(32'h0000_00C2);
    wait_fetch("two_b", 26'h0000104);
    chk("two_head_pc", 64'(inst_pc), 64'(26'h0000100));
    chk("two_head_data", 64'(inst_data), 64'(32'h0000_00C1));
    fetch_valid = 1'b1; fetch_data = 32'h0000_00FF;
    redirect(26'h0002000);
    fetch_valid = 1'b0; fetch_data = '0;
    chk("same_cyc_flush", 64'(inst_valid), 64'(0));
    chk("same_cyc_no_en", 64'(fetch_en), 64'(0));
    tick();
    chk("same_cyc_issue_en", 64'(fetch_en), 64'(1));
    chk("same_cyc_issue_addr", 64'(fetch_addr), 64'(26'h0002000));
    chk("same_cyc_empty", 64'(inst_valid), 64'(0));

    // reset while waiting; a leftover response in IDLE is ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_en", 64'(fetch_en), 64'(0));
    chk("mid_rst_addr", 64'(fetch_addr), 64'(0));
    chk("mid_rst_valid", 64'(inst_valid), 64'(0));
    fetch_valid = 1'b1; fetch_data = 32'h5555_5555;
    tick();
    fetch_valid = 1'b0; fetch_data = '0;
    chk("post_rst_en", 64'(fetch_en), 64'(1));
    chk("post_rst_addr", 64'(fetch_addr), 64'(0));
    chk("spurious_ignored", 64'(inst_valid), 64'(0));
    tick();
    chk("spurious_still_empty", 64'(inst_valid), 64'(0));
    respond(32'h0000_0077);
    chk("post_rst_pc", 64'(inst_pc), 64'(0));
    chk("post_rst_data", 64'(inst_data), 64'(32'h0000_0077));

    // PC wraps modulo 2^26
    redirect(26'h3FFFFFF);
    chk("wrap_flush", 64'(inst_valid), 64'(0));
    wait_fetch("wrap_top", 26'h3FFFFFF);
    respond(32'h0000_0099);
    chk("wrap_pc", 64'(inst_pc), 64'(26'h3FFFFFF));
    wait_fetch("wrap_next", 26'h0000001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
